// File: rtl/fft_pingpong_ctrl.sv
// fft_pingpong_ctrl
// Ping-pong scheduler for two show-ahead sample FIFO banks sitting between
// the ADC capture logic and an Avalon-ST FFT sink. The writer fills the bank
// selected by wr_sel while the reader streams the bank selected by rd_sel as
// one FRAME_LEN-sample frame framed by sink_sop / sink_eop. A per-bank
// registered bank_ready flag hands a complete bank from writer to reader and
// back again once the reader has released it.
// The FIFOs themselves are external and are not flushed here; whoever
// integrates this block clears them together with rst.

module fft_pingpong_ctrl #(
  parameter int FRAME_LEN = 4096,
  parameter int CNT_W     = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       adc_valid,
  output logic [1:0] bank_wr_en,
  output logic [1:0] bank_rd_en,
  input  logic [1:0] bank_empty,
  input  logic       sink_ready,
  output logic       sink_valid,
  output logic       sink_sop,
  output logic       sink_eop,
  output logic       wr_sel,
  output logic       rd_sel,
  output logic       overflow,
  output logic       underflow,
  input  logic       clr_err
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       bank_ready;
  logic [1:0]       bank_ready_nxt;
  logic [CNT_W-1:0] wr_cnt;
  logic [CNT_W-1:0] wr_cnt_nxt;
  logic [CNT_W-1:0] rd_cnt;
  logic [CNT_W-1:0] rd_cnt_nxt;
  logic             wr_sel_nxt;
  logic             rd_sel_nxt;
  logic             overflow_nxt;
  logic             underflow_nxt;

  logic             wr_fire;
  logic             wr_drop;
  logic             wr_done;
  logic             rd_xfer;
  logic             rd_abort;
  logic             rd_release;

  // ---- write side: steer ADC samples into the writer's bank ----
  // A bank still flagged ready belongs to the reader, so the sample is
  // dropped. The flag is registered, so a bank being released this cycle
  // still counts as owned by the reader. Enables are held off during rst so
  // the external FIFOs are left untouched while the integration clears them.
  always_comb begin
    wr_fire    = adc_valid & ~bank_ready[wr_sel] & ~rst;
    wr_drop    = adc_valid & bank_ready[wr_sel];
    wr_done    = wr_fire & (wr_cnt == LAST);
    bank_wr_en = 2'b00;
    bank_wr_en[wr_sel] = wr_fire;
    wr_cnt_nxt = wr_cnt;
    wr_sel_nxt = wr_sel;
    if (wr_fire) begin
      if (wr_done) begin
        wr_cnt_nxt = '0;
        wr_sel_nxt = ~wr_sel;
      end else begin
        wr_cnt_nxt = wr_cnt + CNT_W'(1);
      end
    end
  end

  // ---- read side: frame the reader's bank onto the FFT sink ----
  // In STREAM the show-ahead FIFO presents data whenever it is not empty, so
  // sink_valid follows ~bank_empty directly and sop/eop are held with the
  // data while sink_ready is low. An empty bank mid-frame aborts the frame
  // without eop and releases the bank.
  always_comb begin
    state_nxt  = state;
    rd_cnt_nxt = rd_cnt;
    rd_sel_nxt = rd_sel;
    sink_valid = 1'b0;
    rd_xfer    = 1'b0;
    rd_abort   = 1'b0;
    rd_release = 1'b0;
    unique case (state)
      IDLE: begin
        if (bank_ready[rd_sel]) begin
          state_nxt  = STREAM;
          rd_cnt_nxt = '0;
        end
      end
      STREAM: begin
        sink_valid = ~bank_empty[rd_sel];
        rd_xfer    = sink_valid & sink_ready;
        if (bank_empty[rd_sel]) begin
          rd_abort   = 1'b1;
          rd_release = 1'b1;
          state_nxt  = IDLE;
          rd_cnt_nxt = '0;
          rd_sel_nxt = ~rd_sel;
        end else if (rd_xfer) begin
          if (rd_cnt == LAST) begin
            rd_release = 1'b1;
            state_nxt  = IDLE;
            rd_cnt_nxt = '0;
            rd_sel_nxt = ~rd_sel;
          end else begin
            rd_cnt_nxt = rd_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    sink_sop   = sink_valid & (rd_cnt == '0);
    sink_eop   = sink_valid & (rd_cnt == LAST);
    bank_rd_en = 2'b00;
    bank_rd_en[rd_sel] = rd_xfer & ~rst;
  end

  // ---- bank hand-off and sticky error flags ----
  // Writer and reader always own different banks, so the set from a
  // completed fill and the clear from a released frame never hit the same
  // bit and can both apply in one cycle. A new error event wins over clr_err.
  always_comb begin
    bank_ready_nxt = bank_ready;
    if (wr_done) begin
      bank_ready_nxt[wr_sel] = 1'b1;
    end
    if (rd_release) begin
      bank_ready_nxt[rd_sel] = 1'b0;
    end
    overflow_nxt  = wr_drop  | (overflow  & ~clr_err);
    underflow_nxt = rd_abort | (underflow & ~clr_err);
  end

  // ---- state registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bank_ready <= 2'b00;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      wr_sel     <= 1'b0;
      rd_sel     <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      state      <= state_nxt;
      bank_ready <= bank_ready_nxt;
      wr_cnt     <= wr_cnt_nxt;
      rd_cnt     <= rd_cnt_nxt;
      wr_sel     <= wr_sel_nxt;
      rd_sel     <= rd_sel_nxt;
      overflow   <= overflow_nxt;
      underflow  <= underflow_nxt;
    end
  end

endmodule

// File: tb/tb_fft_pingpong_ctrl.sv
// Bench for fft_pingpong_ctrl with FRAME_LEN=8: two modelled show-ahead
// FIFOs, a transfer scoreboard fed by the stimulus, and directed per-cycle
// checks of framing, ownership and error flags.

module tb_fft_pingpong_ctrl;

  localparam int FRAME_LEN = 8;
  localparam int CNT_W     = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       adc_valid;
  logic [1:0] bank_wr_en;
  logic [1:0] bank_rd_en;
  logic [1:0] bank_empty;
  logic       sink_ready;
  logic       sink_valid;
  logic       sink_sop;
  logic       sink_eop;
  logic       wr_sel;
  logic       rd_sel;
  logic       overflow;
  logic       underflow;
  logic       clr_err;

  int         adc_data;
  logic [1:0] force_empty;
  int         cnt0;
  int         cnt1;
  int         fq0[$];
  int         fq1[$];

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit bank;
    bit sop;
    bit eop;
    int data;
  } xfer_t;

  xfer_t exp_q[$];

  fft_pingpong_ctrl #(
    .FRAME_LEN(FRAME_LEN),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .adc_valid (adc_valid),
    .bank_wr_en(bank_wr_en),
    .bank_rd_en(bank_rd_en),
    .bank_empty(bank_empty),
    .sink_ready(sink_ready),
    .sink_valid(sink_valid),
    .sink_sop  (sink_sop),
    .sink_eop  (sink_eop),
    .wr_sel    (wr_sel),
    .rd_sel    (rd_sel),
    .overflow  (overflow),
    .underflow (underflow),
    .clr_err   (clr_err)
  );

  always #5 clk = ~clk;

  // Show-ahead FIFO models, depth 8, cleared together with rst.
  assign bank_empty = {(cnt1 == 0) | force_empty[1], (cnt0 == 0) | force_empty[0]};

  always @(posedge clk) begin
    if (rst) begin
      fq0.delete();
      fq1.delete();
    end else begin
      if (bank_wr_en[0] && fq0.size() < 8) fq0.push_back(adc_data);
      if (bank_wr_en[1] && fq1.size() < 8) fq1.push_back(adc_data);
      if (bank_rd_en[0] && fq0.size() > 0) void'(fq0.pop_front());
      if (bank_rd_en[1] && fq1.size() > 0) void'(fq1.pop_front());
    end
    cnt0 <= fq0.size();
    cnt1 <= fq1.size();
  end

  function automatic int fifo_head(bit b);
    if (b) return (fq1.size() > 0) ? fq1[0] : -1;
    return (fq0.size() > 0) ? fq0[0] : -1;
  endfunction

  // Scoreboard monitor: every accepted sink transfer pops one expectation.
  always @(negedge clk) begin
    if (!rst && sink_valid && sink_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: transfer on bank %0d sop=%0d eop=%0d, none expected",
                 rd_sel, sink_sop, sink_eop);
      end else begin
        xfer_t e;
        int    d;
        e = exp_q.pop_front();
        d = fifo_head(e.bank);
        if ({rd_sel, sink_sop, sink_eop} !== {e.bank, e.sop, e.eop} ||
            bank_rd_en !== (e.bank ? 2'b10 : 2'b01) || d != e.data) begin
          errors++;
          $display("FAIL sb_xfer: got bank=%0d sop=%0d eop=%0d rd_en=%b data=%0d, expected bank=%0d sop=%0d eop=%0d data=%0d",
                   rd_sel, sink_sop, sink_eop, bank_rd_en, d, e.bank, e.sop, e.eop, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_frame(input bit bank, input int base, input int n, input bit full);
    for (int i = 0; i < n; i++) begin
      xfer_t e;
      e.bank = bank;
      e.sop  = (i == 0);
      e.eop  = full && (i == n - 1);
      e.data = base + i;
      exp_q.push_back(e);
    end
  endtask

  function automatic logic [12:0] all_outs();
    return {bank_wr_en, bank_rd_en, sink_valid, sink_sop, sink_eop,
            wr_sel, rd_sel, overflow, underflow};
  endfunction

  task automatic do_reset();
    rst         = 1'b1;
    adc_valid   = 1'b0;
    sink_ready  = 1'b0;
    clr_err     = 1'b0;
    force_empty = 2'b00;
    adc_data    = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'(all_outs()), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int xfers, sop_x, eop_x;

    // Continuous write and read: two back-to-back frames.
    do_reset();
    push_frame(1'b0, 0, 8, 1'b1);
    push_frame(1'b1, 8, 8, 1'b1);
    for (int c = 0; c < 30; c++) begin
      logic       ev, es, ee;
      logic [1:0] ew;
      adc_valid  = (c < 16);
      adc_data   = c;
      sink_ready = 1'b1;
      ev = (c >= 9 && c <= 16) || (c >= 18 && c <= 25);
      es = (c == 9) || (c == 18);
      ee = (c == 16) || (c == 25);
      ew = (c < 8) ? 2'b01 : ((c < 16) ? 2'b10 : 2'b00);
      @(negedge clk);
      if ({sink_valid, sink_sop, sink_eop, bank_wr_en, overflow} !== {ev, es, ee, ew, 1'b0}) begin
        checks++;
        errors++;
        $display("FAIL t1_cycle%0d: got valid/sop/eop/wr_en/ovf=%b%b%b/%b/%b, expected %b%b%b/%b/0",
                 c, sink_valid, sink_sop, sink_eop, bank_wr_en, overflow, ev, es, ee, ew);
      end else begin
        checks++;
      end
      next_cycle();
    end
    @(negedge clk);
    chk("t1_sel", {30'd0, wr_sel, rd_sel}, 32'h0);
    chk("t1_drained", exp_q.size(), 0);

    // sink_ready toggling during the stream.
    do_reset();
    push_frame(1'b0, 100, 8, 1'b1);
    xfers = 0; sop_x = 0; eop_x = 0;
    for (int c = 0; c < 30; c++) begin
      adc_valid  = (c < 8);
      adc_data   = 100 + c;
      sink_ready = (c % 2 == 0);
      @(negedge clk);
      if (!sink_ready) chk($sformatf("t2_no_rd_c%0d", c), 32'(bank_rd_en), 32'h0);
      if (c == 9)  chk("t2_sop_hold", {29'd0, sink_valid, sink_sop, sink_eop}, 32'h6);
      if (c == 23) chk("t2_eop_hold", {29'd0, sink_valid, sink_sop, sink_eop}, 32'h5);
      if (sink_valid && sink_ready) begin
        xfers++;
        if (sink_sop) sop_x++;
        if (sink_eop) eop_x++;
      end
      next_cycle();
    end
    chk("t2_xfers", xfers, 8);
    chk("t2_sop_count", sop_x, 1);
    chk("t2_eop_count", eop_x, 1);
    chk("t2_drained", exp_q.size(), 0);

    // Overflow with the reader stalled, clr_err behaviour, then drain.
    do_reset();
    push_frame(1'b0, 0, 8, 1'b1);
    push_frame(1'b1, 8, 8, 1'b1);
    for (int c = 0; c < 42; c++) begin
      adc_valid  = (c <= 17);
      adc_data   = c;
      sink_ready = (c >= 20);
      clr_err    = (c == 17) || (c == 18);
      @(negedge clk);
      if (c == 15) chk("t3_wr_en_last", 32'(bank_wr_en), 32'h2);
      if (c == 16) chk("t3_wr_en_stall", {29'd0, bank_wr_en, overflow}, 32'h0);
      if (c == 17) chk("t3_ovf_set", {30'd0, overflow, sink_sop}, 32'h3);
      if (c == 18) chk("t3_ovf_clr_vs_drop", 32'(overflow), 32'h1);
      if (c == 19) chk("t3_ovf_cleared", 32'(overflow), 32'h0);
      next_cycle();
    end
    chk("t3_drained", exp_q.size(), 0);

    // Underflow: bank reads empty at rd_cnt=3.
    do_reset();
    push_frame(1'b0, 0, 3, 1'b0);
    for (int c = 0; c < 18; c++) begin
      adc_valid   = (c < 8);
      adc_data    = c;
      sink_ready  = 1'b1;
      force_empty = (c == 12) ? 2'b01 : 2'b00;
      clr_err     = (c == 14);
      @(negedge clk);
      if (c == 12) chk("t4_abort_cycle", {27'd0, sink_valid, sink_eop, bank_rd_en, underflow}, 32'h0);
      if (c == 13) chk("t4_underflow", {29'd0, underflow, rd_sel, sink_valid}, 32'h6);
      if (c == 15) chk("t4_uf_cleared", {30'd0, underflow, overflow}, 32'h0);
      next_cycle();
    end
    chk("t4_drained", exp_q.size(), 0);

    // Reset mid-frame at rd_cnt=5, wr_cnt=2, then a fresh frame.
    do_reset();
    push_frame(1'b0, 0, 5, 1'b0);
    for (int c = 0; c < 37; c++) begin
      adc_valid  = (c < 8) || (c == 12) || (c == 13) || (c >= 16 && c <= 23);
      adc_data   = (c >= 16) ? (200 + c - 16) : c;
      sink_ready = 1'b1;
      rst        = (c == 14);
      if (c == 15) push_frame(1'b0, 200, 8, 1'b1);
      @(negedge clk);
      if (c == 15) chk("t5_outputs_after_rst", 32'(all_outs()), 32'h0);
      if (c == 25) chk("t5_fresh_sop", {30'd0, sink_valid, sink_sop}, 32'h3);
      if (c == 32) chk("t5_fresh_eop", {30'd0, sink_valid, sink_eop}, 32'h3);
      next_cycle();
    end
    chk("t5_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
